// File: rtl/jtag_pkg.sv
// Shared TAP types, opcodes and instruction decode for the JTAG debug path.
package jtag_pkg;

  localparam int IR_WIDTH = 4;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_t;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_ID,
    SEL_BSR
  } dr_sel_t;

  typedef struct packed {
    dr_sel_t sel;
    logic    mode;
    logic    dm_reset;
  } ir_decode_t;

  localparam logic [IR_WIDTH-1:0] EXTEST         = 4'b0000;
  localparam logic [IR_WIDTH-1:0] IDCODE         = 4'b0001;
  localparam logic [IR_WIDTH-1:0] SAMPLE_PRELOAD = 4'b0010;
  localparam logic [IR_WIDTH-1:0] INTEST         = 4'b0011;
  localparam logic [IR_WIDTH-1:0] DBG_RESET      = 4'b1000;
  localparam logic [IR_WIDTH-1:0] BYPASS         = 4'b1111;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE     = 4'b0101;

  // Unlisted opcodes fall through to bypass so an unknown instruction is harmless.
  function automatic ir_decode_t decode_ir(input logic [IR_WIDTH-1:0] ir);
    ir_decode_t d;
    d.sel      = SEL_BYPASS;
    d.mode     = 1'b0;
    d.dm_reset = 1'b0;
    case (ir)
      EXTEST, INTEST: begin
        d.sel  = SEL_BSR;
        d.mode = 1'b1;
      end
      SAMPLE_PRELOAD: d.sel = SEL_BSR;
      IDCODE:         d.sel = SEL_ID;
      DBG_RESET:      d.dm_reset = 1'b1;
      BYPASS:         d.sel = SEL_BYPASS;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/jtag_tap_controller_if.sv
// Serial TAP pins plus the control bundle driven toward the boundary-scan chain.
interface jtag_tap_controller_if;
  import jtag_pkg::*;

  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                bsr_tdo;
  logic                bsr_tdi;
  logic                bsr_capture;
  logic                bsr_shift;
  logic                bsr_update;
  logic                bsr_mode;
  logic                dm_reset;
  logic [IR_WIDTH-1:0] ir_value;

  modport master (
    output tms, tdi, bsr_tdo,
    input  tdo, bsr_tdi, bsr_capture, bsr_shift, bsr_update, bsr_mode, dm_reset, ir_value
  );

  modport slave (
    input  tms, tdi, bsr_tdo,
    output tdo, bsr_tdi, bsr_capture, bsr_shift, bsr_update, bsr_mode, dm_reset, ir_value
  );

endinterface

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine: state register and next-state logic only.
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_next;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state <= TEST_LOGIC_RESET;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TEST_LOGIC_RESET: state_next = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        state_next = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       state_next = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_next = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_next = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_next = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_next = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        state_next = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_next = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_next = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_next = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_next = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_next = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_next = tms ? SELECT_DR        : RUN_TEST_IDLE;
    endcase
  end

endmodule

// File: rtl/jtag_tap_controller.sv
// TAP controller: instruction register, IDCODE/BYPASS data registers and
// instruction decode driving the boundary-scan chain and the core debug reset.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h1BEE_F0A3
) (
  input  logic                  tck,
  input  logic                  trst,
  jtag_tap_controller_if.slave  tap
);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_latch;
  logic [31:0]         id_shift;
  logic                bypass_bit;
  logic                tdo_q;
  logic                tlr_entry;
  ir_decode_t          dec;

  tap_fsm u_tap_fsm (
    .tck   (tck),
    .trst  (trst),
    .tms   (tap.tms),
    .state (state)
  );

  // SELECT_IR with tms=1 is the only way into TLR, so the reload lands on the entry edge.
  assign tlr_entry = (state == TEST_LOGIC_RESET) || ((state == SELECT_IR) && tap.tms);
  assign dec       = decode_ir(ir_latch);

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_shift <= '0;
      ir_latch <= IDCODE;
    end else begin
      case (state)
        CAPTURE_IR: ir_shift <= IR_CAPTURE;
        SHIFT_IR:   ir_shift <= {tap.tdi, ir_shift[IR_WIDTH-1:1]};
        default: ;
      endcase
      if (tlr_entry)               ir_latch <= IDCODE;
      else if (state == UPDATE_IR) ir_latch <= ir_shift;
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      id_shift   <= '0;
      bypass_bit <= 1'b0;
    end else if (state == CAPTURE_DR) begin
      id_shift   <= IDCODE_VALUE;
      bypass_bit <= 1'b0;
    end else if (state == SHIFT_DR) begin
      if (dec.sel == SEL_ID)     id_shift   <= {tap.tdi, id_shift[31:1]};
      if (dec.sel == SEL_BYPASS) bypass_bit <= tap.tdi;
    end
  end

  // tdo changes on the falling edge so the far end samples it stable on the next rising edge.
  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo_q <= 1'b0;
    end else begin
      case (state)
        SHIFT_IR: tdo_q <= ir_shift[0];
        SHIFT_DR: begin
          case (dec.sel)
            SEL_ID:  tdo_q <= id_shift[0];
            SEL_BSR: tdo_q <= tap.bsr_tdo;
            default: tdo_q <= bypass_bit;
          endcase
        end
        default: tdo_q <= 1'b0;
      endcase
    end
  end

  always_comb begin
    tap.bsr_capture = 1'b0;
    tap.bsr_shift   = 1'b0;
    tap.bsr_update  = 1'b0;
    if (dec.sel == SEL_BSR) begin
      tap.bsr_capture = (state == CAPTURE_DR);
      tap.bsr_shift   = (state == SHIFT_DR);
      tap.bsr_update  = (state == UPDATE_DR);
    end
  end

  assign tap.tdo      = tdo_q;
  assign tap.bsr_tdi  = tap.tdi;
  assign tap.bsr_mode = dec.mode;
  assign tap.dm_reset = dec.dm_reset;
  assign tap.ir_value = ir_latch;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Scoreboard bench for the TAP controller: scan tasks push per-cycle expectations
// from a queue-based register model; a monitor pops and compares on each falling edge.
module tb_jtag_tap_controller;

  localparam logic [31:0] ID_VAL = 32'h1BEE_F0A3;

  typedef enum int {PH_OTHER, PH_TLR, PH_CAPDR, PH_SHDR, PH_UPDR,
                    PH_CAPIR, PH_SHIR, PH_UPIR} phase_t;

  typedef struct {
    bit       tdo, cap, shf, upd, mode, dmr, btdi;
    bit [3:0] ir;
  } exp_t;

  logic tck  = 1'b0;
  logic trst = 1'b1;

  jtag_tap_controller_if tap_if ();

  jtag_tap_controller #(.IDCODE_VALUE(ID_VAL)) dut (
    .tck  (tck),
    .trst (trst),
    .tap  (tap_if)
  );

  always #5 tck = ~tck;

  int          total = 0;
  int          bad   = 0;
  exp_t        expq[$];
  bit          irq[$];
  bit          drq[$];
  bit [3:0]    m_ir;
  phase_t      ph;
  logic [31:0] id_word;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_bsr(input bit [3:0] ir);
    return (ir == 4'd0) || (ir == 4'd2) || (ir == 4'd3);
  endfunction

  function automatic bit is_id(input bit [3:0] ir);
    return ir == 4'd1;
  endfunction

  task automatic model_reset();
    irq.delete();
    drq.delete();
    m_ir = 4'b0001;
    ph   = PH_TLR;
  endtask

  // One tck: drive inputs after the falling edge, then record what the DUT
  // should show for the cycle that begins at the rising edge.
  task automatic tick(input bit t_ms, input bit t_di, input bit t_bsr, input phase_t nph);
    exp_t e;
    bit   sel_bsr;
    @(negedge tck); #2;
    tap_if.tms     = t_ms;
    tap_if.tdi     = t_di;
    tap_if.bsr_tdo = t_bsr;
    @(posedge tck);
    case (ph)
      PH_CAPIR: irq = '{1'b1, 1'b0, 1'b1, 1'b0};
      PH_SHIR: begin
        void'(irq.pop_front());
        irq.push_back(t_di);
      end
      PH_UPIR: m_ir = {irq[3], irq[2], irq[1], irq[0]};
      PH_CAPDR: begin
        drq.delete();
        if (is_id(m_ir)) for (int i = 0; i < 32; i++) drq.push_back(id_word[i]);
        else if (!is_bsr(m_ir)) drq.push_back(1'b0);
      end
      PH_SHDR: if (!is_bsr(m_ir)) begin
        void'(drq.pop_front());
        drq.push_back(t_di);
      end
      default: ;
    endcase
    if (nph == PH_TLR) m_ir = 4'b0001;
    ph      = nph;
    sel_bsr = is_bsr(m_ir);
    e.ir    = m_ir;
    e.mode  = (m_ir == 4'd0) || (m_ir == 4'd3);
    e.dmr   = (m_ir == 4'b1000);
    e.cap   = sel_bsr && (ph == PH_CAPDR);
    e.shf   = sel_bsr && (ph == PH_SHDR);
    e.upd   = sel_bsr && (ph == PH_UPDR);
    e.btdi  = t_di;
    if (ph == PH_SHIR)      e.tdo = irq[0];
    else if (ph == PH_SHDR) e.tdo = sel_bsr ? t_bsr : drq[0];
    else                    e.tdo = 1'b0;
    expq.push_back(e);
  endtask

  // Scan tasks start and end in Run-Test/Idle; pause_i < 0 means no pause.
  task automatic scan_ir(input logic [3:0] v, input int pause_i);
    tick(1, rb(), rb(), PH_OTHER);
    tick(1, rb(), rb(), PH_OTHER);
    tick(0, rb(), rb(), PH_CAPIR);
    tick(0, rb(), rb(), PH_SHIR);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) tick(1, v[i], rb(), PH_OTHER);
      else if (i == pause_i) begin
        tick(1, v[i], rb(), PH_OTHER);
        tick(0, rb(), rb(), PH_OTHER);
        tick(0, rb(), rb(), PH_OTHER);
        tick(1, rb(), rb(), PH_OTHER);
        tick(0, rb(), rb(), PH_SHIR);
      end else tick(0, v[i], rb(), PH_SHIR);
    end
    tick(1, rb(), rb(), PH_UPIR);
    tick(0, rb(), rb(), PH_OTHER);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] data, input int pause_i);
    tick(1, rb(), rb(), PH_OTHER);
    tick(0, rb(), rb(), PH_CAPDR);
    tick(0, rb(), rb(), PH_SHDR);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) tick(1, data[i], rb(), PH_OTHER);
      else if (i == pause_i) begin
        tick(1, data[i], rb(), PH_OTHER);
        tick(0, rb(), rb(), PH_OTHER);
        tick(0, rb(), rb(), PH_OTHER);
        tick(1, rb(), rb(), PH_OTHER);
        tick(0, rb(), rb(), PH_SHDR);
      end else tick(0, data[i], rb(), PH_SHDR);
    end
    tick(1, rb(), rb(), PH_UPDR);
    tick(0, rb(), rb(), PH_OTHER);
  endtask

  task automatic five_ones_from_rti(input int extra);
    tick(1, rb(), rb(), PH_OTHER);
    tick(1, rb(), rb(), PH_OTHER);
    for (int i = 0; i < 3 + extra; i++) tick(1, rb(), rb(), PH_TLR);
    tick(0, rb(), rb(), PH_OTHER);
  endtask

  task automatic five_ones_from_shdr();
    tick(1, rb(), rb(), PH_OTHER);
    tick(0, rb(), rb(), PH_CAPDR);
    tick(0, rb(), rb(), PH_SHDR);
    for (int i = 0; i < 3; i++) tick(0, rb(), rb(), PH_SHDR);
    tick(1, rb(), rb(), PH_OTHER);
    tick(1, rb(), rb(), PH_UPDR);
    tick(1, rb(), rb(), PH_OTHER);
    tick(1, rb(), rb(), PH_OTHER);
    tick(1, rb(), rb(), PH_TLR);
    tick(0, rb(), rb(), PH_OTHER);
  endtask

  task automatic check_reset(input string tag);
    chk4({tag, "_ir"},   tap_if.ir_value,    4'b0001);
    chk1({tag, "_tdo"},  tap_if.tdo,         1'b0);
    chk1({tag, "_cap"},  tap_if.bsr_capture, 1'b0);
    chk1({tag, "_shf"},  tap_if.bsr_shift,   1'b0);
    chk1({tag, "_upd"},  tap_if.bsr_update,  1'b0);
    chk1({tag, "_mode"}, tap_if.bsr_mode,    1'b0);
    chk1({tag, "_dmr"},  tap_if.dm_reset,    1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge tck); #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk1("tdo",         tap_if.tdo,         e.tdo);
        chk1("bsr_capture", tap_if.bsr_capture, e.cap);
        chk1("bsr_shift",   tap_if.bsr_shift,   e.shf);
        chk1("bsr_update",  tap_if.bsr_update,  e.upd);
        chk1("bsr_mode",    tap_if.bsr_mode,    e.mode);
        chk1("dm_reset",    tap_if.dm_reset,    e.dmr);
        chk1("bsr_tdi",     tap_if.bsr_tdi,     e.btdi);
        chk4("ir_value",    tap_if.ir_value,    e.ir);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [3:0] ops[6];
    logic [3:0] op;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1111};
    id_word        = ID_VAL;
    tap_if.tms     = 1'b1;
    tap_if.tdi     = 1'b0;
    tap_if.bsr_tdo = 1'b0;
    model_reset();

    repeat (3) @(posedge tck);
    #1 check_reset("reset");
    @(negedge tck); #2;
    trst = 1'b0;

    tick(0, rb(), rb(), PH_OTHER);
    five_ones_from_shdr();
    scan_dr(32, {$urandom, $urandom}, -1);

    scan_ir(4'b1111, -1);
    scan_dr(8, 64'hB2, -1);

    scan_ir(4'b0010, 1);
    scan_dr(12, {$urandom, $urandom}, 5);
    scan_ir(4'b0000, -1);
    scan_dr(5, {$urandom, $urandom}, -1);
    scan_ir(4'b1000, -1);
    tick(0, rb(), rb(), PH_OTHER);
    five_ones_from_rti(0);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
      else                           op = ops[$urandom_range(0, 5)];
      scan_ir(op, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1);
      scan_dr(int'($urandom_range(1, 40)), {$urandom, $urandom},
              ($urandom_range(0, 2) == 0) ? 0 : -1);
      if ($urandom_range(0, 3) == 0) five_ones_from_rti(int'($urandom_range(0, 3)));
    end

    scan_ir(4'b0011, -1);
    tick(1, rb(), rb(), PH_OTHER);
    tick(1, rb(), rb(), PH_OTHER);
    tick(0, rb(), rb(), PH_CAPIR);
    tick(0, rb(), rb(), PH_SHIR);
    tick(0, 1'b0, rb(), PH_SHIR);
    tick(0, 1'b0, rb(), PH_SHIR);
    @(negedge tck); #3;
    trst = 1'b1;
    #1 check_reset("trst_mid");
    model_reset();
    repeat (2) @(posedge tck);
    #1 check_reset("trst_hold");
    @(negedge tck); #2;
    trst = 1'b0;
    tick(0, rb(), rb(), PH_OTHER);
    scan_ir(4'b0001, -1);
    scan_dr(32, {$urandom, $urandom}, -1);

    repeat (2) @(posedge tck);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
IEEE 1149.1-style TAP controller for the debug path. It owns the 16-state TAP FSM, the instruction register, and the IDCODE and BYPASS data registers. It decodes the current instruction into the enables, mode and debug-reset controls that drive the boundary-scan chain (PCF / InstrF / MemWriteM / DataAdrM / WriteDataM / ReadDataM cells) and the core reset. It sits directly upstream of the BSR chain: it feeds bsr_tdi and consumes bsr_tdo.

Parameters:
IR_WIDTH, 4, instruction register width.
IDCODE_VALUE, 32'h1BEE_F0A3, value captured into the ID register. Bit 0 must be 1.

Ports:
tck  input  1  TAP clock; all state changes on rising edge unless noted.
trst  input  1  asynchronous, active-high reset.
tms  input  1  mode select, sampled on rising tck.
tdi  input  1  serial data in, sampled on rising tck.
tdo  output  1  serial data out, updated on falling tck.
bsr_tdo  input  1  serial return from the last BSR cell.
bsr_tdi  output  1  serial feed into the first BSR cell (= tdi).
bsr_capture  output  1  BSR parallel-load enable.
bsr_shift  output  1  BSR shift enable.
bsr_update  output  1  BSR update-latch enable.
bsr_mode  output  1  1 = BSR outputs drive from update latch; 0 = transparent.
dm_reset  output  1  debug reset request to the core.
ir_value  output  IR_WIDTH  current latched instruction (debug visibility).

Behaviour:
- Reset (trst=1, async), values hold while asserted:
  - state = TEST_LOGIC_RESET
  - IR latch = IDCODE; IR shift reg = 0
  - bypass reg = 0; tdo = 0
  - bsr_capture/shift/update = 0, bsr_mode = 0, dm_reset = 0
- FSM: standard 1149.1 transitions on rising tck, using tms:
  - TLR -(0)-> RTI
  - RTI -(1)-> SELECT_DR
  - SELECT_DR -(0)-> CAPTURE_DR, -(1)-> SELECT_IR; SELECT_IR -(1)-> TLR
  - CAPTURE -(0)-> SHIFT, -(1)-> EXIT1
  - SHIFT -(1)-> EXIT1
  - EXIT1 -(0)-> PAUSE, -(1)-> UPDATE
  - PAUSE -(1)-> EXIT2
  - EXIT2 -(0)-> SHIFT, -(1)-> UPDATE
  - UPDATE -(0)-> RTI, -(1)-> SELECT_DR
  - Five consecutive tms=1 reach TLR from any state.
  - Entering TLR synchronously reloads IR latch = IDCODE and clears dm_reset.
- Instructions (4-bit); all other codes decode as BYPASS:
  - 0000 EXTEST: selects BSR, mode=1.
  - 0001 IDCODE: selects ID register.
  - 0010 SAMPLE_PRELOAD: selects BSR, mode=0.
  - 0011 INTEST: selects BSR, mode=1.
  - 1000 DBG_RESET: selects bypass, dm_reset=1.
  - 1111 BYPASS: selects bypass.
- IR path:
  - CAPTURE_IR loads shift reg with 4'b0101.
  - SHIFT_IR shifts right: tdi enters the MSB, the LSB goes to tdo.
  - UPDATE_IR copies the shift reg to the IR latch on the rising edge leaving UPDATE_IR.
  - Decoded outputs (bsr_mode, dm_reset) change the same edge.
- DR path, per selected register:
  - ID: CAPTURE_DR loads IDCODE_VALUE; SHIFT_DR shifts right, LSB first.
  - Bypass: CAPTURE_DR loads 0; SHIFT_DR loads tdi, giving 1-cycle delay.
  - BSR: bsr_capture = (state==CAPTURE_DR)&bsr_sel; bsr_shift = (state==SHIFT_DR)&bsr_sel; bsr_update = (state==UPDATE_DR)&bsr_sel.
  - BSR enables are combinational from state and IR; the BSR acts on the next rising tck.
- tdo: on falling tck, register
  - IR-shift LSB in SHIFT_IR;
  - selected DR LSB / bypass / bsr_tdo in SHIFT_DR;
  - otherwise 0.
- PAUSE states hold all shift registers unchanged.
- trst mid-shift: partial shift contents are discarded, and the IR latch returns to IDCODE immediately.

Decomposition:
- jtag_pkg holds:
  - tap_state_t enum (16 states);
  - IR_WIDTH;
  - opcode localparams (EXTEST, IDCODE, SAMPLE_PRELOAD, INTEST, DBG_RESET, BYPASS);
  - IR_CAPTURE = 4'b0101.
- Sub-module tap_fsm contains only the state register and next-state logic, with inputs tck, trst, tms and output state.
- IR, DR and decode logic stay in the parent.

Test Plan:
- Reset + tck with tms=1,1,1,1,1 from SHIFT_DR -> state TLR, ir_value=4'b0001, tdo=0.
- From RTI: SELECT_DR, CAPTURE_DR, then 32 SHIFT_DR cycles -> tdo shows 32'h1BEE_F0A3 LSB first (1,1,0,0,0,1,0,1...).
- Shift IR with tdi=1111 -> tdo emits 1,0,1,0 (capture 0101). After UPDATE_IR, 8 SHIFT_DR bits 10110010 -> tdo echoes each bit delayed by one tck.
- Load SAMPLE_PRELOAD (0010) -> bsr_mode=0; bsr_capture=1 exactly in CAPTURE_DR, bsr_shift=1 in SHIFT_DR, bsr_update=1 in UPDATE_DR; bsr_tdo toggling appears on tdo one falling edge later.
- Load EXTEST -> bsr_mode=1. Load DBG_RESET (1000) -> dm_reset=1 from the edge leaving UPDATE_IR. Five tms=1 -> dm_reset=0, ir_value=0001.
- Assert trst mid SHIFT_IR after 2 bits -> immediate TLR, ir_value=0001, all bsr enables 0, tdo=0.
